tv_recorder: RTL
================

// Module: tv_recorder
// PURPOSE
//   Writer side of the test-vector flow: captures one packed {stimulus,response} word per
//   qualified cycle into an on-chip buffer. The buffer is later streamed out in capture order
//   over a valid/ready port, to a UART/JTAG dumper or a bench, in $readmemb-ready order.
//   Sits beside a DUT (e.g. mux_4_1) in hardware self-test builds of the multi-cycle core.
// PARAMETERS
//   WIDTH  17   bits per vector word, e.g. {select[1:0],in1..in4[2:0],out[2:0]}
//   DEPTH  101  buffer entries (words 0..DEPTH-1)
//   RW     3    response-field width, in_word[RW-1:0]; used only with TVREC_CHECK_EN
// PORTS
//   clk        in   1                 clock, all state changes on posedge
//   reset      in   1                 synchronous, active-low
//   start      in   1                 pulse: clear buffer, begin recording
//   stop       in   1                 pulse: end recording
//   in_valid   in   1                 in_word is to be captured this cycle
//   in_word    in   WIDTH             vector word to capture
//   dump_req   in   1                 pulse: stream buffer contents out
//   out_valid  out  1                 out_word holds a valid word
//   out_ready  in   1                 sink accepts out_word this cycle
//   out_word   out  WIDTH             streamed vector word
//   out_last   out  1                 out_word is entry count-1
//   count      out  $clog2(DEPTH+1)   words captured
//   full       out  1                 count==DEPTH
//   overflow   out  1                 sticky: a word was dropped while not recording
//   busy       out  1                 state is RECORD or DUMP
// BEHAVIOUR
//   - reset==0 at posedge: state IDLE; wr/rd pointers 0; count, full, overflow, out_valid,
//     out_last, out_word, busy all 0. Applies mid-RECORD or mid-DUMP. Buffer RAM is not cleared.
//   - States: IDLE -> RECORD -> HOLD -> DUMP -> HOLD.
//   - IDLE:   start -> RECORD, count:=0, overflow:=0.
//             dump_req with count>0 -> DUMP. dump_req with count==0 is ignored.
//   - RECORD: in_valid writes mem[count] and count+1 at the same edge.
//             The write that makes count==DEPTH also moves to HOLD and sets full.
//             stop -> HOLD; an in_valid in the same cycle is still captured.
//             start restarts recording: count:=0, and any in_valid that cycle is dropped.
//             start has priority over stop. dump_req is ignored.
//   - HOLD:   in_valid is dropped and sets overflow.
//             start -> RECORD (restart). dump_req with count>0 -> DUMP.
//   - DUMP:   dump_req sampled at edge N -> out_valid=1 with word 0 after edge N+1.
//             Transfer occurs when out_valid && out_ready. After a transfer, the next word is
//             valid at the next edge, with no bubbles.
//             out_word is held stable while out_valid && !out_ready.
//             out_last=1 only with entry count-1.
//             After the last transfer: out_valid=0, rd pointer:=0, state HOLD, count kept,
//             so a redump is allowed.
//             start, stop, dump_req and in_valid are ignored; in_valid sets overflow.
//   - Buffer is synchronous-read RAM. The read address is pointer+fire, for zero-bubble streaming.
//   - No wrap-around: recording never overwrites. Once DEPTH is reached, capture stops.
// CONFIGURATION
//   TVREC_CHECK_EN defined:
//     - Adds input exp_word[RW-1:0] and output err_count[15:0].
//     - On each captured word, in_word[RW-1:0]!=exp_word increments err_count, saturating
//       at 16'hFFFF.
//     - err_count is cleared by reset or start.
//   TVREC_CHECK_EN undefined: these ports and the logic are absent. All other behaviour is identical.
// TESTING
//   - Reset mid-DUMP:
//     - Stimulus: reset=0 for 1 cycle at beat 2.
//     - Response: next cycle out_valid=0, count=0, state IDLE.
//     - Follow-up: a later dump_req yields no output.
//   - Record/dump order:
//     - Stimulus: start; 5 in_valid words 17'h00001..17'h00005; stop; dump_req; out_ready=1.
//     - Response: 5 beats 1..5 on consecutive cycles; out_last only on 5; count=5; returns to HOLD.
//   - Fill to full:
//     - Stimulus: start; 103 consecutive in_valid.
//     - Response: count=101, full=1, state HOLD; overflow=1.
//     - Dump check: the dump returns the first 101 words, with out_last on word 100.
//   - Backpressure:
//     - Stimulus: dump 3 words; out_ready=0 for 4 cycles at beat 1.
//     - Response: out_word is held at word 1 and out_valid stays 1; no word is lost or duplicated.
//   - Edge cases:
//     - dump_req with count==0: ignored, out_valid stays 0.
//     - stop+in_valid in the same cycle: the word is captured.
//     - start+stop in the same cycle: state RECORD, count=0.
//   - TVREC_CHECK_EN:
//     - Stimulus: 4 words with in_word[2:0]=3'b101 against exp_word 101, 100, 101, 000.
//     - Response: err_count=2; next start clears it to 0.

Source files
------------

// File: rtl/tv_recorder.sv
// Test-vector recorder: captures {stimulus,response} words into a sync-read buffer and
// streams them back in capture order over valid/ready. Optional checker: TVREC_CHECK_EN.
module tv_recorder #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 101
`ifdef TVREC_CHECK_EN
  ,
  parameter int RW    = 3
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_word,
  input  logic                         dump_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_word,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow,
  output logic                         busy
`ifdef TVREC_CHECK_EN
  ,
  input  logic [RW-1:0]                exp_word,
  output logic [15:0]                  err_count
`endif
);

  // state    | meaning
  // S_IDLE   | after reset, buffer considered empty
  // S_RECORD | capturing in_valid words at mem[count]
  // S_HOLD   | capture finished, contents kept for (re)dump
  // S_DUMP   | streaming mem[0..count-1] out
  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_HOLD, S_DUMP} state_e;

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            out_valid_q, out_valid_d;
  logic            wr_en;
  logic            fire;
  logic            is_last;
  logic [CW-1:0]   count_inc;
  logic [CW-1:0]   rd_next;
  logic [CW-1:0]   rd_addr;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] mem [DEPTH];

  assign fire      = (state_q == S_DUMP) && out_valid_q && out_ready;
  assign is_last   = (rd_ptr_q == count_q - ONE);
  assign count_inc = count_q + ONE;
  // Look one entry ahead on a transfer so the next word lands with no bubble.
  assign rd_next   = rd_ptr_q + (fire ? ONE : '0);
  assign rd_addr   = (rd_next < DEPTH_C) ? rd_next : '0;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    wr_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RECORD;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (dump_req && (count_q != '0)) begin
          state_d     = S_DUMP;
          rd_ptr_d    = '0;
          out_valid_d = 1'b0;
        end
      end
      S_RECORD: begin
        if (start) begin
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          if (in_valid) begin
            wr_en   = 1'b1;
            count_d = count_inc;
            if (count_inc == DEPTH_C) state_d = S_HOLD;
          end
          if (stop) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (start) begin
          state_d    = S_RECORD;
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          if (in_valid) overflow_d = 1'b1;
          if (dump_req && (count_q != '0)) begin
            state_d     = S_DUMP;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
          end
        end
      end
      S_DUMP: begin
        if (in_valid) overflow_d = 1'b1;
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          if (is_last) begin
            out_valid_d = 1'b0;
            rd_ptr_d    = '0;
            state_d     = S_HOLD;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Buffer RAM: not reset, synchronous read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q] <= in_word;
    rd_data_q <= mem[rd_addr];
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_valid_q ? rd_data_q : '0;
  assign out_last  = out_valid_q && is_last;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign overflow  = overflow_q;
  assign busy      = (state_q == S_RECORD) || (state_q == S_DUMP);

`ifdef TVREC_CHECK_EN
  logic [15:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start && ((state_q == S_IDLE) || (state_q == S_RECORD) || (state_q == S_HOLD))) begin
      err_d = '0;
    end else if (wr_en && (in_word[RW-1:0] != exp_word) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule
